// File: rtl/op_select_counter.sv
// Key-driven modulo-MODULUS up/down operation-select counter with synchronised key inputs.
// Optional per-key debounce filter is enabled by defining OP_SELECT_COUNTER_DEBOUNCE_EN.
module op_select_counter #(
  parameter int WIDTH           = 3,
  parameter int MODULUS         = 6,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_up,
  input  logic             key_down,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             wrap
);

  generate
    if (MODULUS < 2 || longint'(MODULUS) > (64'd1 << WIDTH) ||
        SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("op_select_counter: illegal parameters WIDTH=%0d MODULUS=%0d SYNC_STAGES=%0d DEBOUNCE_CYCLES=%0d",
             WIDTH, MODULUS, SYNC_STAGES, DEBOUNCE_CYCLES);
    end
  endgenerate

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  logic [1:0] raw;
  logic [1:0] press;

  assign raw = {key_down, key_up};

  // All key-path flops reset to 1 so a key held through reset release never counts.
  for (genvar k = 0; k < 2; k++) begin : g_key
    logic [SYNC_STAGES-1:0] sync;
    logic                   level;
    logic                   hist;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= '1;
      else     sync <= {sync[SYNC_STAGES-2:0], raw[k]};
    end

`ifdef OP_SELECT_COUNTER_DEBOUNCE_EN
    localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LOAD = CW'(DEBOUNCE_CYCLES);
    logic [CW-1:0] cnt;
    logic          stable;

    // Level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stable <= 1'b1;
        cnt    <= LOAD;
      end else if (sync[SYNC_STAGES-1] == stable) begin
        cnt <= LOAD;
      end else if (cnt <= CW'(1)) begin
        stable <= sync[SYNC_STAGES-1];
        cnt    <= LOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end

    assign level = stable;
`else
    assign level = sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) hist <= 1'b1;
      else     hist <= level;
    end

    assign press[k] = level & ~hist;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
      case (press)
        2'b01: begin
          step <= 1'b1;
          if (count == TOP) begin
            count <= '0;
            wrap  <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        2'b10: begin
          step <= 1'b1;
          if (count == '0) begin
            count <= TOP;
            wrap  <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_op_select_counter.sv
// Directed bench for op_select_counter: reset, wrap in both directions, simultaneous keys,
// hold, clr-vs-press priority, async reset mid-run and (when enabled) debounce behaviour.
module tb_op_select_counter;

`ifdef OP_SELECT_COUNTER_DEBOUNCE_EN
  localparam int LAT = 2 + 16;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst, key_up, key_down, clr;
  logic [2:0] count;
  logic       step, wrap;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [2:0] cur      = 3'd0;
  int         steps;

  op_select_counter #(.WIDTH(3), .MODULUS(6), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down), .clr(clr),
    .count(count), .step(step), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Raise keys, confirm nothing moves before the latency, then check the landing cycle.
  task automatic press(input string tag, input logic up, input logic dn,
                       input logic [2:0] exp_cnt, input logic exp_step, input logic exp_wrap);
    key_up = up; key_down = dn;
    repeat (LAT) tick();
    chk({tag, "_early_cnt"}, count, cur);
    chk({tag, "_early_step"}, step, 1'b0);
    tick();
    chk({tag, "_cnt"}, count, exp_cnt);
    chk({tag, "_step"}, step, exp_step);
    chk({tag, "_wrap"}, wrap, exp_wrap);
    cur = exp_cnt;
    key_up = 1'b0; key_down = 1'b0;
    tick();
    chk({tag, "_step_off"}, step, 1'b0);
    chk({tag, "_wrap_off"}, wrap, 1'b0);
    repeat (LAT + 2) tick();
  endtask

  initial begin
    logic [2:0] up_exp [6];
    up_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    rst = 1'b1; key_up = 1'b0; key_down = 1'b0; clr = 1'b0;
    repeat (3) tick();
    chk("reset_count", count, 3'd0);
    chk("reset_step", step, 1'b0);
    chk("reset_wrap", wrap, 1'b0);
    rst = 1'b0;
    repeat (LAT + 3) tick();
    chk("idle_count", count, 3'd0);

    for (int i = 0; i < 6; i++)
      press($sformatf("up%0d", i), 1'b1, 1'b0, up_exp[i], 1'b1, i == 5);

    press("dn_wrap", 1'b0, 1'b1, 3'd5, 1'b1, 1'b1);
    press("dn_4", 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
    press("dn_3", 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
    press("dn_2", 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    press("both", 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);

    // Holding a key gives exactly one step.
    steps = 0;
    key_up = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (step) steps++;
    end
    chk("hold_steps", 8'(steps), 8'd1);
    chk("hold_count", count, 3'd3);
    key_up = 1'b0;
    repeat (LAT + 2) tick();

    // clr in the landing cycle wins and the press is lost.
    key_up = 1'b1;
    repeat (LAT) tick();
    clr = 1'b1;
    tick();
    chk("clr_count", count, 3'd0);
    chk("clr_step", step, 1'b0);
    clr = 1'b0;
    cur = 3'd0;
    steps = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (step) steps++;
    end
    chk("clr_after_steps", 8'(steps), 8'd0);
    chk("clr_after_count", count, 3'd0);
    key_up = 1'b0;
    repeat (LAT + 2) tick();

    for (int i = 1; i <= 4; i++)
      press($sformatf("pre_rst%0d", i), 1'b1, 1'b0, 3'(i), 1'b1, 1'b0);

    // Asynchronous reset mid-cycle, key held across release.
    rst = 1'b1;
    #2;
    chk("async_rst_count", count, 3'd0);
    chk("async_rst_step", step, 1'b0);
    chk("async_rst_wrap", wrap, 1'b0);
    key_up = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    cur = 3'd0;
    steps = 0;
    for (int i = 0; i < LAT + 8; i++) begin
      tick();
      if (step) steps++;
    end
    chk("held_rst_steps", 8'(steps), 8'd0);
    chk("held_rst_count", count, 3'd0);
    key_up = 1'b0;
    repeat (LAT + 3) tick();
    press("repress", 1'b1, 1'b0, 3'd1, 1'b1, 1'b0);

`ifdef OP_SELECT_COUNTER_DEBOUNCE_EN
    for (int i = 0; i < 3; i++) begin
      key_up = 1'b1; repeat (5) tick();
      key_up = 1'b0; repeat (5) tick();
    end
    chk("bounce_count", count, 3'd1);
    key_up = 1'b1;
    repeat (LAT) tick();
    chk("db_early_count", count, 3'd1);
    tick();
    chk("db_count", count, 3'd2);
    chk("db_step", step, 1'b1);
    tick();
    key_up = 1'b0;
    repeat (LAT + 4) tick();
    key_up = 1'b1; repeat (10) tick();
    key_up = 1'b0;
    steps = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (step) steps++;
    end
    chk("pulse_steps", 8'(steps), 8'd0);
    chk("pulse_count", count, 3'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
